// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: drives one shared hex decoder and
// time-slices common-anode digits, with blanking gaps and frame-atomic updates.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  localparam int IW = $clog2(NUM_DIGITS),
  localparam int CW = $clog2(((SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES) + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  output logic                    load_ack,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    lzb,
  output logic [3:0]              numin_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [IW-1:0]           dig_idx,
  output logic                    frame_done
);

  // Load handshake: load is a one-cycle request with no ready; it is always
  // accepted into hold. load_ack is a one-cycle pulse issued the cycle after
  // the frame boundary at which the most recent held value became visible.

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam bit          HAS_BLANK  = (BLANK_CYCLES > 0);
  localparam state_t      START      = HAS_BLANK ? BLANK : SHOW;
  localparam logic [CW-1:0] BLANK_LAST = CW'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [IW-1:0]           idx_nxt;
  logic [4*NUM_DIGITS-1:0] hold, hold_nxt;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
  logic                    pending, pending_nxt;
  logic                    boundary;
  logic                    commit;
  logic [IW-1:0]           msnz;
  logic                    den_bit;
  logic                    visible;
  logic [3:0]              numin_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = dig_idx;
    boundary  = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_nxt = START;
          cnt_nxt   = '0;
          boundary  = (dig_idx == IDX_LAST);
          idx_nxt   = (dig_idx == IDX_LAST) ? '0 : dig_idx + IW'(1);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = START;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // A load in the boundary cycle lands in hold but leaves pending set, so it
  // is committed one frame later rather than racing the current commit.
  always_comb begin
    commit      = boundary && pending;
    shadow_nxt  = commit ? hold : shadow;
    hold_nxt    = load ? value : hold;
    pending_nxt = load ? 1'b1 : (commit ? 1'b0 : pending);
  end

  // Outputs are computed for the upcoming cycle and registered, using the
  // shadow contents that will be current then.
  always_comb begin
    msnz      = '0;
    numin_nxt = 4'h0;
    den_bit   = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (shadow_nxt[4*k +: 4] != 4'h0) msnz = IW'(k);
      if (idx_nxt == IW'(k)) begin
        numin_nxt = shadow_nxt[4*k +: 4];
        den_bit   = dig_en[k];
      end
    end
    visible = (state_nxt == SHOW) && den_bit && !(lzb && (idx_nxt > msnz));
    an_nxt  = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (visible && (idx_nxt == IW'(k))) an_nxt[k] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= START;
      cnt        <= '0;
      dig_idx    <= '0;
      hold       <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      an_n       <= '1;
      numin_out  <= 4'h0;
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      dig_idx    <= idx_nxt;
      hold       <= hold_nxt;
      shadow     <= shadow_nxt;
      pending    <= pending_nxt;
      an_n       <= an_nxt;
      numin_out  <= numin_nxt;
      load_ack   <= commit;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a time-based reference model (frame position from a
// cycle counter) predicts every output each cycle; directed scenarios add checks.
module tb_seg_scan_ctrl;
  localparam int N     = 4;
  localparam int S     = 4;
  localparam int B     = 1;
  localparam int STEP  = B + S;
  localparam int FRAME = N * STEP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  dig_en = 4'hF;
  logic        lzb = 1'b0;
  logic        load_ack;
  logic [3:0]  numin_out;
  logic [3:0]  an_n;
  logic [1:0]  dig_idx;
  logic        frame_done;

  seg_scan_ctrl #(.NUM_DIGITS(N), .SHOW_CYCLES(S), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .load_ack(load_ack),
    .dig_en(dig_en), .lzb(lzb), .numin_out(numin_out), .an_n(an_n),
    .dig_idx(dig_idx), .frame_done(frame_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_t;
  logic [15:0] m_hold, m_shadow;
  logic        m_pending;
  logic [3:0]  m_den;
  logic        m_lzb;
  logic [3:0]  e_an, e_num;
  logic [1:0]  e_idx;
  logic        e_ack, e_fd;
  logic [3:0]  exp_q[$];

  function automatic int top_nz(input logic [15:0] v);
    int m = 0;
    for (int k = 0; k < N; k++) if (v[4*k +: 4] != 4'h0) m = k;
    return m;
  endfunction

  task automatic model_outputs();
    int pos, d;
    pos   = m_t % FRAME;
    d     = pos / STEP;
    e_idx = 2'(d);
    e_num = m_shadow[4*d +: 4];
    e_an  = 4'hF;
    if ((pos % STEP) >= B && m_den[d] && !(m_lzb && d > top_nz(m_shadow))) e_an[d] = 1'b0;
  endtask

  task automatic model_reset();
    m_t = 0; m_hold = '0; m_shadow = '0; m_pending = 1'b0;
    m_den = dig_en; m_lzb = lzb; e_ack = 1'b0; e_fd = 1'b0;
    model_outputs();
  endtask

  task automatic model_edge();
    logic bnd;
    bnd   = (m_t % FRAME) == FRAME - 1;
    e_ack = bnd && m_pending;
    e_fd  = bnd;
    if (e_ack) begin
      m_shadow  = m_hold;
      m_pending = 1'b0;
    end
    if (load) begin
      m_hold    = value;
      m_pending = 1'b1;
    end
    m_den = dig_en;
    m_lzb = lzb;
    m_t++;
    model_outputs();
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; load = 1'b0; value = '0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  function automatic string got_exp();
    return $sformatf("got an=%b num=%h idx=%0d ack=%b fd=%b, expected an=%b num=%h idx=%0d ack=%b fd=%b",
                     an_n, numin_out, dig_idx, load_ack, frame_done, e_an, e_num, e_idx, e_ack, e_fd);
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({an_n, dig_idx, numin_out, load_ack, frame_done} !== {4'hF, 2'd0, 4'h0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_hold got an=%b idx=%0d num=%h ack=%b fd=%b, expected an=1111 idx=0 num=0 ack=0 fd=0",
               an_n, dig_idx, numin_out, load_ack, frame_done);
    end
    dig_en = 4'hF; lzb = 1'b0;
    do_reset();
    n_checks++;
    if ({an_n, numin_out, dig_idx, load_ack, frame_done} !== {e_an, e_num, e_idx, e_ack, e_fd}) begin
      n_errors++; $display("FAIL reset_release %s", got_exp());
    end
  endtask

  task automatic test_idle_scan();
    int fd_cnt = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      n_checks++;
      if ({an_n, numin_out, dig_idx, load_ack, frame_done} !== {e_an, e_num, e_idx, e_ack, e_fd}) begin
        n_errors++; $display("FAIL idle_scan t=%0d %s", t, got_exp());
      end
      if (frame_done === 1'b1) fd_cnt++;
    end
    n_checks++;
    if (fd_cnt != 2) begin
      n_errors++; $display("FAIL idle_frame_done_count got %0d expected 2", fd_cnt);
    end
  endtask

  task automatic test_load_commit();
    logic [3:0] digs [4] = '{4'hF, 4'h3, 4'hA, 4'h1};
    logic [3:0] want;
    do_reset();
    exp_q.delete();
    for (int d = 0; d < 4; d++) repeat (S) exp_q.push_back(digs[d]);
    for (int t = 0; t < 40; t++) begin
      n_checks++;
      if ({an_n, numin_out, dig_idx, load_ack, frame_done} !== {e_an, e_num, e_idx, e_ack, e_fd}) begin
        n_errors++; $display("FAIL load_commit t=%0d %s", t, got_exp());
      end
      if (t == 20) begin
        n_checks++;
        if ({load_ack, frame_done} !== 2'b11) begin
          n_errors++; $display("FAIL load_ack_at_20 got ack=%b fd=%b expected ack=1 fd=1", load_ack, frame_done);
        end
      end
      if (t >= 20 && (t % STEP) >= B && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        n_checks++;
        if (numin_out !== want) begin
          n_errors++; $display("FAIL load_display t=%0d got %h expected %h", t, numin_out, want);
        end
      end
      load  = (t == 3);
      value = 16'h1A3F;
      tick();
    end
    load = 1'b0;
  endtask

  task automatic test_overwrite();
    int acks = 0;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      n_checks++;
      if ({an_n, numin_out, dig_idx, load_ack, frame_done} !== {e_an, e_num, e_idx, e_ack, e_fd}) begin
        n_errors++; $display("FAIL overwrite t=%0d %s", t, got_exp());
      end
      if (load_ack === 1'b1) acks++;
      if (t >= 20) begin
        n_checks++;
        if (numin_out !== 4'h2) begin
          n_errors++; $display("FAIL overwrite_nibble t=%0d got %h expected 2", t, numin_out);
        end
      end
      load  = (t == 5) || (t == 9);
      value = (t == 5) ? 16'h1111 : 16'h2222;
      tick();
    end
    load = 1'b0;
    n_checks++;
    if (acks != 1) begin
      n_errors++; $display("FAIL overwrite_ack_count got %0d expected 1", acks);
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    int ack_t[$];
    logic [15:0] shown;
    do_reset();
    for (int t = 0; t < 60; t++) begin
      n_checks++;
      if ({an_n, numin_out, dig_idx, load_ack, frame_done} !== {e_an, e_num, e_idx, e_ack, e_fd}) begin
        n_errors++; $display("FAIL back_to_back t=%0d %s", t, got_exp());
      end
      if (load_ack === 1'b1) ack_t.push_back(t);
      if (t >= 20) begin
        shown = (t < 40) ? 16'h0011 : 16'h0042;
        n_checks++;
        if (numin_out !== shown[4*((t % FRAME) / STEP) +: 4]) begin
          n_errors++; $display("FAIL boundary_display t=%0d got %h expected %h",
                               t, numin_out, shown[4*((t % FRAME) / STEP) +: 4]);
        end
      end
      load  = (t == 10) || (t == FRAME - 1);
      value = (t == 10) ? 16'h0011 : 16'h0042;
      tick();
    end
    load = 1'b0;
    acks = ack_t.size();
    n_checks++;
    if (acks != 2 || ack_t[0] != 20 || ack_t[1] != 40) begin
      n_errors++;
      $display("FAIL boundary_acks got count=%0d first=%0d second=%0d expected count=2 at 20 and 40",
               acks, (acks > 0) ? ack_t[0] : -1, (acks > 1) ? ack_t[1] : -1);
    end
  endtask

  task automatic test_lzb();
    int lit2 [4] = '{0, 0, 0, 0};
    int lit3 [4] = '{0, 0, 0, 0};
    do_reset();
    lzb = 1'b1;
    for (int t = 0; t < 60; t++) begin
      n_checks++;
      if ({an_n, numin_out, dig_idx, load_ack, frame_done} !== {e_an, e_num, e_idx, e_ack, e_fd}) begin
        n_errors++; $display("FAIL lzb t=%0d %s", t, got_exp());
      end
      for (int d = 0; d < 4; d++) begin
        if (t >= 20 && t < 40 && an_n[d] === 1'b0) lit2[d]++;
        if (t >= 40 && an_n[d] === 1'b0) lit3[d]++;
      end
      if (t >= 40 && an_n[0] === 1'b0) begin
        n_checks++;
        if (numin_out !== 4'h0) begin
          n_errors++; $display("FAIL lzb_zero_digit t=%0d got %h expected 0", t, numin_out);
        end
      end
      load  = (t == 1) || (t == 25);
      value = (t == 1) ? 16'h0042 : 16'h0000;
      tick();
    end
    load = 1'b0;
    lzb  = 1'b0;
    n_checks++;
    if (lit2[0] != S || lit2[1] != S || lit2[2] != 0 || lit2[3] != 0) begin
      n_errors++; $display("FAIL lzb_0042_lit got %0d %0d %0d %0d expected %0d %0d 0 0",
                           lit2[0], lit2[1], lit2[2], lit2[3], S, S);
    end
    n_checks++;
    if (lit3[0] != S || lit3[1] != 0 || lit3[2] != 0 || lit3[3] != 0) begin
      n_errors++; $display("FAIL lzb_0000_lit got %0d %0d %0d %0d expected %0d 0 0 0",
                           lit3[0], lit3[1], lit3[2], lit3[3], S);
    end
  endtask

  task automatic test_dig_en_reset();
    int dark_hits = 0;
    dig_en = 4'b0101;
    do_reset();
    for (int t = 0; t <= 32; t++) begin
      n_checks++;
      if ({an_n, numin_out, dig_idx, load_ack, frame_done} !== {e_an, e_num, e_idx, e_ack, e_fd}) begin
        n_errors++; $display("FAIL dig_en t=%0d %s", t, got_exp());
      end
      if (an_n[1] === 1'b0 || an_n[3] === 1'b0) dark_hits++;
      if (t == 32) break;
      load  = (t == 2);
      value = 16'h5A5A;
      tick();
    end
    load = 1'b0;
    n_checks++;
    if (dark_hits != 0) begin
      n_errors++; $display("FAIL dig_en_dark got %0d lit cycles on digits 1/3 expected 0", dark_hits);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({an_n, dig_idx, numin_out} !== {4'hF, 2'd0, 4'h0}) begin
      n_errors++; $display("FAIL midscan_reset got an=%b idx=%0d num=%h expected an=1111 idx=0 num=0",
                           an_n, dig_idx, numin_out);
    end
    dig_en = 4'hF;
    do_reset();
    for (int t = 0; t < FRAME; t++) begin
      n_checks++;
      if ({an_n, numin_out, dig_idx, load_ack, frame_done} !== {e_an, e_num, e_idx, e_ack, e_fd}) begin
        n_errors++; $display("FAIL after_reset t=%0d %s", t, got_exp());
      end
      n_checks++;
      if (numin_out !== 4'h0) begin
        n_errors++; $display("FAIL shadow_cleared t=%0d got %h expected 0", t, numin_out);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    do_reset();
    for (int t = 0; t < 400; t++) begin
      n_checks++;
      if ({an_n, numin_out, dig_idx, load_ack, frame_done} !== {e_an, e_num, e_idx, e_ack, e_fd}) begin
        n_errors++; $display("FAIL random t=%0d %s", t, got_exp());
      end
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom) & masks[$urandom_range(0, 4)];
      if ($urandom_range(0, 9) == 0) dig_en = 4'($urandom);
      if ($urandom_range(0, 15) == 0) lzb = ~lzb;
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_load_commit();
    test_overwrite();
    test_back_to_back();
    test_lzb();
    test_dig_en_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
